store_write_buffer: RTL

- Sits between the CPU data-memory port and the data memory/D-cache; its memory-side outputs (mem_addr, mem_wdata, mem_wen) drive the address/data/write-enable bus the result-checking bench monitors.
- Buffers CPU stores in a small in-order FIFO and drains them to memory one at a time.
- Separates consecutive writes with one idle cycle, so each store appears exactly once as a distinct mem_wen pulse, even across memory stalls.
- Forces loads to wait until all buffered stores have drained, preserving program order.

---
 rtl/store_write_buffer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/store_write_buffer.sv
// In-order store buffer between the CPU data port and data memory.
// Stores queue in a FIFO and drain one per write pulse, with an idle
// cycle between writes; loads wait until the buffer is fully drained.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   cpu_wen/cpu_ren   CPU store / load request
//   cpu_addr/wdata    CPU word address and store data
//   cpu_rdata         load data (always mem_rdata)
//   cpu_stall         CPU must hold its request
//   mem_wen/mem_ren   memory write / read strobes
//   mem_addr/wdata    memory address and write data
//   mem_rdata         memory read data
//   mem_stall         memory busy, current request held
//   wr_done_cnt       saturating count of completed writes
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wen,
    input  logic        cpu_ren,
    input  logic [29:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_stall,
    output logic [15:0] wr_done_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        GAP
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    state_t           state;
    state_t           state_nx;
    logic [29:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [29:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             full;
    logic             busy;
    logic             push;
    logic             pop;
    logic             load_ok;

    assign full = (count == FULL_CNT);
    // A load may only pass once nothing is queued and the drain
    // FSM has returned to IDLE (including the trailing GAP cycle).
    assign busy = (count != '0) || (state != IDLE);
    // Full is judged on the registered count, so a same-cycle pop
    // never makes room for a push.
    assign push = rst && cpu_wen && !full;
    assign pop = rst && (state == WRITE) && !mem_stall;
    assign load_ok = rst && cpu_ren && !busy;
    assign cpu_rdata = mem_rdata;

    always_comb begin
        state_nx = state;
        mem_wen = 1'b0;
        mem_ren = 1'b0;
        cpu_stall = 1'b0;
        // Bus holds its last value when nothing is driving it.
        mem_addr = addr_q;
        mem_wdata = wdata_q;
        unique case (state)
            IDLE: begin
                if (count != '0) state_nx = WRITE;
            end
            WRITE: begin
                mem_wen = rst;
                mem_addr = addr_mem[head];
                mem_wdata = data_mem[head];
                if (!mem_stall) state_nx = GAP;
            end
            GAP: begin
                state_nx = (count != '0) ? WRITE : IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (load_ok) begin
            mem_ren = 1'b1;
            mem_addr = cpu_addr;
            cpu_stall = mem_stall;
        end
        if (rst && cpu_ren && busy) cpu_stall = 1'b1;
        if (rst && cpu_wen && full) cpu_stall = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            head <= '0;
            tail <= '0;
            count <= '0;
            wr_done_cnt <= '0;
            addr_q <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nx;
            addr_q <= mem_addr;
            wdata_q <= mem_wdata;
            if (push) tail <= tail + PTR_W'(1);
            if (pop) begin
                head <= head + PTR_W'(1);
                if (wr_done_cnt != 16'hFFFF)
                    wr_done_cnt <= wr_done_cnt + 16'd1;
            end
            unique case ({push, pop})
                2'b10: count <= count + (PTR_W + 1)'(1);
                2'b01: count <= count - (PTR_W + 1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= cpu_addr;
            data_mem[tail] <= cpu_wdata;
        end
    end

endmodule
